// File: rtl/instr_encoder.sv
// Two-stage valid/ready encoder that packs RV32I instruction fields into a 32-bit word.
// It also range-checks the immediate for the selected format.
module instr_encoder (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  fmt_i,
    input  logic [4:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic        imm_err_o
);

    typedef enum logic [2:0] {
        FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ, FmtCsri, FmtIll
    } fmt_e;

    logic        s1_valid_q;
    fmt_e        s1_fmt_q;
    logic [4:0]  s1_op_q, s1_rd_q, s1_rs1_q, s1_rs2_q;
    logic [2:0]  s1_f3_q;
    logic [6:0]  s1_f7_q;
    logic [31:0] s1_imm_q;

    logic        s2_valid_q;
    logic [31:0] instr_q;
    logic        err_q;

    logic        s2_ready, s1_advance, accept;
    logic [31:0] word_d;
    logic        err_d;
    logic [6:0]  low7;
    logic        fits12, fits13, fits21;

    // Backpressure depends only on downstream state, never on req_valid_i.
    assign s2_ready    = !s2_valid_q || instr_ready_i;
    assign s1_advance  = s1_valid_q && s2_ready;
    assign req_ready_o = !s1_valid_q || s1_advance;
    assign accept      = req_valid_i && req_ready_o;

    assign instr_valid_o = s2_valid_q;
    assign instr_o       = instr_q;
    assign imm_err_o     = err_q;

    // Signed-range checks: upper bits must be a pure sign extension.
    assign low7   = {s1_op_q, 2'b11};
    assign fits12 = (s1_imm_q[31:11] == {21{s1_imm_q[11]}});
    assign fits13 = (s1_imm_q[31:12] == {20{s1_imm_q[12]}});
    assign fits21 = (s1_imm_q[31:20] == {12{s1_imm_q[20]}});

    always_comb begin
        word_d = '0;
        err_d  = 1'b0;
        case (s1_fmt_q)
            FmtR: word_d = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, low7};
            FmtI: begin
                word_d = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, low7};
                err_d  = !fits12;
            end
            FmtS: begin
                word_d = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_imm_q[4:0], low7};
                err_d  = !fits12;
            end
            FmtB: begin
                word_d = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                          s1_imm_q[4:1], s1_imm_q[11], low7};
                err_d  = !fits13 || s1_imm_q[0];
            end
            FmtU: begin
                word_d = {s1_imm_q[31:12], s1_rd_q, low7};
                err_d  = (s1_imm_q[11:0] != 12'h000);
            end
            FmtJ: begin
                word_d = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                          s1_rd_q, low7};
                err_d  = !fits21 || s1_imm_q[0];
            end
            FmtCsri: begin
                word_d = {s1_f7_q, s1_rs2_q, s1_imm_q[4:0], s1_f3_q, s1_rd_q, low7};
                err_d  = (s1_imm_q[31:5] != 27'd0);
            end
            default: begin
                word_d = '0;
                err_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            s1_valid_q <= 1'b0;
            s1_fmt_q   <= FmtR;
            s1_op_q    <= '0;
            s1_rd_q    <= '0;
            s1_rs1_q   <= '0;
            s1_rs2_q   <= '0;
            s1_f3_q    <= '0;
            s1_f7_q    <= '0;
            s1_imm_q   <= '0;
        end else begin
            if (accept) begin
                s1_valid_q <= 1'b1;
                s1_fmt_q   <= fmt_e'(fmt_i);
                s1_op_q    <= opcode_i;
                s1_rd_q    <= rd_i;
                s1_rs1_q   <= rs1_i;
                s1_rs2_q   <= rs2_i;
                s1_f3_q    <= funct3_i;
                s1_f7_q    <= funct7_i;
                s1_imm_q   <= imm_i;
            end else if (s1_advance) begin
                s1_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            s2_valid_q <= 1'b0;
            instr_q    <= '0;
            err_q      <= 1'b0;
        end else if (s2_ready) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                instr_q <= word_d;
                err_q   <= err_d;
            end
        end
    end

endmodule
